// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - digit-serial two's-complement subtractor with borrow/overflow/zero flags
module serial_subtractor #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             overflow,
   output logic             zero
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_dsh;
   logic             r_a_msb;
   logic             r_b_msb;
   logic             r_bor;
   logic [CW-1:0]    r_cnt;
   logic [DIGIT:0]   w_sub;
   logic             w_last;

   // Extra top bit of the digit subtract goes negative exactly when a borrow is needed.
   assign w_sub  = {1'b0, r_a[DIGIT-1:0]} - {1'b0, r_b[DIGIT-1:0]} - {{DIGIT{1'b0}}, r_bor};
   assign w_last = (r_cnt == CW'(N));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      ready  = 1'b0;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            ready = 1'b1;
            if (start) w_next = S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            if (w_last) w_next = S_DONE;
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_dsh    <= '0;
         r_a_msb  <= 1'b0;
         r_b_msb  <= 1'b0;
         r_bor    <= 1'b0;
         r_cnt    <= '0;
         diff     <= '0;
         borrow   <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
      end else if (r_state == S_IDLE && start) begin
         r_a     <= a;
         r_b     <= b;
         r_a_msb <= a[WIDTH-1];
         r_b_msb <= b[WIDTH-1];
         r_bor   <= 1'b0;
         r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
         if (!w_last) begin
            r_a   <= r_a >> DIGIT;
            r_b   <= r_b >> DIGIT;
            r_dsh <= {w_sub[DIGIT-1:0], r_dsh[WIDTH-1:DIGIT]};
            r_bor <= w_sub[DIGIT];
            r_cnt <= r_cnt + CW'(1);
         end else begin
            // Operand MSBs were saved at capture since the shift registers are drained by now.
            diff     <= r_dsh;
            borrow   <= r_bor;
            overflow <= (r_a_msb != r_b_msb) && (r_dsh[WIDTH-1] != r_a_msb);
            zero     <= (r_dsh == '0);
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized self-checking bench for serial_subtractor (DIGIT=1 and DIGIT=4)
module tb_serial_subtractor;

   logic        clk = 1'b0;
   logic        rst;
   logic        start1, start4;
   logic [31:0] a, b;
   logic        ready1, busy1, done1, borrow1, ovf1, zero1;
   logic        ready4, busy4, done4, borrow4, ovf4, zero4;
   logic [31:0] diff1, diff4;
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(32), .DIGIT(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a), .b(b),
      .ready(ready1), .busy(busy1), .done(done1), .diff(diff1),
      .borrow(borrow1), .overflow(ovf1), .zero(zero1)
   );

   serial_subtractor #(.WIDTH(32), .DIGIT(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a), .b(b),
      .ready(ready4), .busy(busy4), .done(done4), .diff(diff4),
      .borrow(borrow4), .overflow(ovf4), .zero(zero4)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic run_op(input int dg, input logic [31:0] ia, input logic [31:0] ib, input bit poke);
      logic [31:0] ed;
      logic        eb, eo;
      longint      sd;
      int          edges;
      int          lat;
      ed  = ia - ib;
      eb  = (ia < ib);
      sd  = longint'($signed(ia)) - longint'($signed(ib));
      eo  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      lat = 32 / dg + 1;

      @(negedge clk);
      a = ia;
      b = ib;
      if (dg == 1) start1 = 1'b1; else start4 = 1'b1;
      check("ready_before", (dg == 1) ? ready1 : ready4, 1);
      @(posedge clk); #1;
      start1 = 1'b0;
      start4 = 1'b0;
      check("busy_after_accept", (dg == 1) ? busy1 : busy4, 1);

      edges = 0;
      while (edges < 100) begin
         if ((dg == 1) ? done1 : done4) break;
         if (poke && edges == 5) begin
            a = 32'd9;
            b = 32'd1;
            start1 = 1'b1;
         end else if (poke && edges == 6) begin
            start1 = 1'b0;
         end
         @(posedge clk); #1;
         edges++;
      end
      check("latency", edges, lat);
      check("diff",     (dg == 1) ? diff1   : diff4,   ed);
      check("borrow",   (dg == 1) ? borrow1 : borrow4, eb);
      check("overflow", (dg == 1) ? ovf1    : ovf4,    eo);
      check("zero",     (dg == 1) ? zero1   : zero4,   ed == 0);

      @(posedge clk); #1;
      check("done_one_cycle", (dg == 1) ? done1 : done4, 0);
      check("ready_after",    (dg == 1) ? ready1 : ready4, 1);
      repeat (2) @(posedge clk);
      #1;
      check("done_stays_low", (dg == 1) ? done1 : done4, 0);
      check("diff_hold",      (dg == 1) ? diff1 : diff4, ed);
   endtask

   initial begin
      int ndone;
      rst    = 1'b0;
      start1 = 1'b0;
      start4 = 1'b0;
      a      = '0;
      b      = '0;
      #2 rst = 1'b1;
      #1;
      check("rst_ready",  ready1, 1);
      check("rst_busy",   busy1, 0);
      check("rst_done",   done1, 0);
      check("rst_diff",   diff1, 0);
      check("rst_flags",  {borrow1, ovf1, zero1}, 0);
      check("rst_ready4", ready4, 1);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run_op(1, 32'd100, 32'd58, 0);
      run_op(1, 32'd5, 32'd7, 0);
      run_op(1, 32'h8000_0000, 32'd1, 0);
      run_op(1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(1, 32'h0000_1234, 32'h0000_1234, 1);
      run_op(4, 32'hDEAD_BEEF, 32'h1234_5678, 0);
      run_op(4, 32'd0, 32'd1, 0);

      for (int i = 0; i < 12; i++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         rb = (i % 4 == 0) ? ra : $urandom;
         run_op(1, ra, rb, 0);
         run_op(4, $urandom, $urandom, 0);
      end

      @(negedge clk);
      a      = $urandom;
      b      = $urandom;
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("midrst_ready", ready1, 1);
      check("midrst_busy",  busy1, 0);
      check("midrst_done",  done1, 0);
      check("midrst_diff",  diff1, 0);
      check("midrst_flags", {borrow1, ovf1, zero1}, 0);
      repeat (2) @(negedge clk);
      rst   = 1'b0;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done1) ndone++;
      end
      check("midrst_no_done", ndone, 0);
      run_op(1, $urandom, $urandom, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Multi-cycle two's-complement subtractor for the ALU datapath. It computes DIFF = A - B, DIGIT bits per clock, starting at the LSB and propagating a borrow bit between cycles. It also reports unsigned borrow, signed overflow and zero flags. It is used where area matters more than latency and uses a start/done handshake toward the ALU control.

Parameters:
WIDTH, 32, operand and result width in bits
DIGIT, 1, bits processed per clock; must divide WIDTH exactly (N = WIDTH/DIGIT cycles)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when ready=1
a  input  WIDTH  minuend; captured on the accepted start edge
b  input  WIDTH  subtrahend; captured on the accepted start edge
ready  output  1  high when idle and able to accept start
busy  output  1  high while digits are being processed
done  output  1  one-cycle pulse: diff and flags valid
diff  output  WIDTH  A - B modulo 2^WIDTH
borrow  output  1  1 when A < B unsigned (inverse of carry-out)
overflow  output  1  signed overflow of A - B
zero  output  1  1 when diff == 0

Behaviour:
- Clocking: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, ready=1, busy=0, done=0, diff=0, borrow=0, overflow=0, zero=0. Internal operand registers, digit counter and borrow register are all cleared.
- States:
  - IDLE: ready=1. When start=1 at a clock edge, latch a and b, clear the borrow register and the counter, and go to RUN.
  - RUN: busy=1, ready=0. Each cycle:
    - Subtract the low DIGIT bits of the A and B shift registers, minus the borrow register, using a DIGIT-bit subtract with borrow-in/borrow-out.
    - Shift the result digit into the top of the diff shift register; shift A and B right by DIGIT.
    - Update the borrow register and increment the counter.
    - After the N-th digit, go to DONE.
  - DONE: held for exactly one cycle. done=1, ready=0, busy=0. Then go to IDLE.
- Latency: with start accepted at edge k, done is high in the cycle following edge k+N+1. Example: N=32 gives done 33 edges after acceptance.
- Flags are computed on entry to DONE:
  - borrow = final borrow register.
  - overflow = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]), using the latched A and B.
  - zero = (diff == 0).
- Output hold: diff and the flags change only on entry to DONE or on reset. They hold their values through the following IDLE period until the next result.
- Input capture: a and b are sampled only on the accepted start edge. Later changes to a or b do not affect the operation in progress.
- start while busy or in DONE: ignored. There is no queuing and no effect on the current operation.
- start held high continuously: a new operation is accepted on the first IDLE edge after DONE.
- Reset mid-operation: aborts immediately and returns to reset values. No done pulse is generated.
- Wrap-around: diff is always modulo 2^WIDTH. The borrow and overflow flags carry the information about out-of-range results.

Test Plan:
- WIDTH=32, DIGIT=1: a=100, b=58, start pulse -> done exactly 33 edges later; diff=42, borrow=0, overflow=0, zero=0.
- a=5, b=7 -> diff=0xFFFFFFFE, borrow=1, overflow=0, zero=0.
- a=0x80000000, b=1 -> diff=0x7FFFFFFF, borrow=0, overflow=1. Then a=0x7FFFFFFF, b=0xFFFFFFFF -> diff=0x80000000, borrow=1, overflow=1.
- a=b=0x00001234 -> diff=0, zero=1, borrow=0. While busy, pulse start with a=9, b=1 -> ignored; result unchanged; exactly one done pulse.
- DIGIT=4: a=0xDEADBEEF, b=0x12345678 -> done 9 edges after acceptance; diff=0xCC796877, borrow=0.
- Assert rst 10 cycles into a DIGIT=1 operation -> ready=1, diff=0, all flags 0, no done pulse. A new start after reset release completes normally with the correct result.
